apb_req_arbiter: RTL

//  Shares one APB master port between NUM_REQ local requesters.

---
 rtl/apb_req_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin share of one APB master port among
// NUM_REQ local requesters, with an optional ACCESS-phase timeout.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req                per-requester level request, held until done
//   req_addr/req_write/req_wdata  packed per-requester command slices
//   done               one-cycle completion pulse to the winner
//   rsp_rdata/rsp_err  response, valid only in the done cycle
//   busy               high from SETUP through ACCESS completion
//   psel..pwdata       APB master outputs
//   prdata/pready/pslverr  APB slave inputs
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    done,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic [AW-1:0]         paddr,
  output logic                  pwrite,
  output logic [DW-1:0]         pwdata,
  input  logic [DW-1:0]         prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e               state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        win_q;
  logic [CW-1:0]        cnt_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [DW-1:0]        rdata_q;
  logic                 err_q;
  logic                 busy_q;
  logic                 psel_q;
  logic                 penable_q;
  logic [AW-1:0]        paddr_q;
  logic                 pwrite_q;
  logic [DW-1:0]        pwdata_q;

  logic [IW-1:0]        win_d;
  logic [IW:0]          scan;
  logic                 hit;
  logic [AW-1:0]        addr_d;
  logic [DW-1:0]        wdata_d;
  logic                 write_d;
  logic [IW-1:0]        ptr_d;
  logic                 tmo;
  logic                 fin;

  // Scan from ptr upward, wrapping; first set request wins.
  always_comb begin
    hit   = 1'b0;
    win_d = ptr_q;
    scan  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NUM_REQ))
        scan = scan - (IW+1)'(NUM_REQ);
      if (!hit && req[scan[IW-1:0]]) begin
        hit   = 1'b1;
        win_d = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    write_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_d == IW'(i)) begin
        addr_d  = req_addr[i*AW +: AW];
        wdata_d = req_wdata[i*DW +: DW];
        write_d = req_write[i];
      end
    end
  end

  assign ptr_d = (win_q == IW'(NUM_REQ-1)) ?
                 '0 : win_q + IW'(1);

  // Timeout fires on the last allowed stalled ACCESS cycle.
  assign tmo = TMO_EN && (cnt_q == TMO_LAST) && !pready;
  assign fin = pready || tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      // Response fields live for exactly one cycle.
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            win_q    <= win_d;
            paddr_q  <= addr_d;
            pwrite_q <= write_d;
            pwdata_q <= wdata_d;
            psel_q   <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (fin) begin
            done_q    <= NUM_REQ'(1) << win_q;
            rdata_q   <= (pwrite_q || tmo) ?
                         '0 : prdata;
            err_q     <= tmo ? 1'b1 : pslverr;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            ptr_q     <= ptr_d;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule
